// File: rtl/irq_arbiter.sv
// Memory-mapped interrupt arbiter: latches source edges, masks/routes them onto two
// processor interrupt lines and runs a raise/ack handshake per line. Define IRQ_TIMEOUT_EN
// to add an ack timeout per line with a sticky flag in CAUSE_x[6].
module irq_arbiter #(
    parameter int          NUM_SRC        = 4,
    parameter logic [7:0]  BASE_ADDR      = 8'hE0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_REQ,
    output logic [1:0]         BUS_INTERRUPTS_RAISE,
    input  logic [1:0]         BUS_INTERRUPTS_ACK
);

    localparam logic [8:0] SRC_TOP  = 9'd1 << NUM_SRC;
    localparam logic [7:0] SRC_MASK = 8'(SRC_TOP - 9'd1);

    localparam logic [7:0] OFF_PENDING = 8'd0;
    localparam logic [7:0] OFF_ENABLE  = 8'd1;
    localparam logic [7:0] OFF_ROUTE   = 8'd2;
    localparam logic [7:0] OFF_CAUSE_A = 8'd3;
    localparam logic [7:0] OFF_CAUSE_B = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAISE,
        ST_HOLDOFF
    } line_state_t;

    logic [7:0]  req_pad;
    logic [7:0]  req_q;
    logic [7:0]  req_qq;
    logic [7:0]  rise;

    logic [7:0]  pending;
    logic [7:0]  pending_nxt;
    logic [7:0]  enable;
    logic [7:0]  route;

    line_state_t state       [2];
    logic [2:0]  cause_idx   [2];
    logic        cause_valid [2];
    logic        cause_to    [2];
    logic [1:0]  raise_q;

    logic [7:0]  eligible [2];
    logic [7:0]  ack_clr;
    logic [7:0]  w1c;
    logic [7:0]  cause_byte [2];

    logic [7:0]  offset;
    logic        in_win;
    logic        wr_hit;
    logic        rd_hit;
    logic [7:0]  wdata;
    logic [7:0]  rd_mux;
    logic [7:0]  rd_data;
    logic        rd_drive;

`ifdef IRQ_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] to_cnt [2];
`endif

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    assign offset  = BUS_ADDR - BASE_ADDR;
    assign in_win  = (offset < 8'd5);
    assign wr_hit  = in_win && BUS_WE;
    assign rd_hit  = in_win && !BUS_WE;
    assign wdata   = BUS_DATA & SRC_MASK;
    assign rise    = req_q & ~req_qq & SRC_MASK;

    assign BUS_DATA             = rd_drive ? rd_data : 8'bz;
    assign BUS_INTERRUPTS_RAISE = raise_q;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        req_pad              = '0;
        req_pad[NUM_SRC-1:0] = SRC_REQ;

        eligible[0] = pending & enable & ~route;
        eligible[1] = pending & enable & route;

        ack_clr = '0;
        for (int l = 0; l < 2; l++) begin
            if (state[l] == ST_RAISE && BUS_INTERRUPTS_ACK[l]) ack_clr[cause_idx[l]] = 1'b1;
`ifdef IRQ_TIMEOUT_EN
            cause_byte[l] = {cause_valid[l], cause_to[l], 3'b000, cause_idx[l]};
`else
            cause_byte[l] = {cause_valid[l], 4'b0000, cause_idx[l]};
`endif
        end

        w1c = (wr_hit && offset == OFF_PENDING) ? wdata : 8'h00;
        // A new edge always beats a clear landing on the same bit in the same cycle.
        pending_nxt = ((pending & ~(ack_clr | w1c)) | rise) & SRC_MASK;

        case (offset)
            OFF_PENDING: rd_mux = pending;
            OFF_ENABLE:  rd_mux = enable;
            OFF_ROUTE:   rd_mux = route;
            OFF_CAUSE_A: rd_mux = cause_byte[0];
            OFF_CAUSE_B: rd_mux = cause_byte[1];
            default:     rd_mux = 8'h00;
        endcase
    end

    // NOTE: all state, including the edge-detect history, is cleared by reset so nothing
    // stale can produce a spurious edge or raise after reset is released.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            req_q    <= '0;
            req_qq   <= '0;
            pending  <= '0;
            enable   <= '0;
            route    <= '0;
            rd_data  <= '0;
            rd_drive <= 1'b0;
            raise_q  <= '0;
            for (int l = 0; l < 2; l++) begin
                state[l]       <= ST_IDLE;
                cause_idx[l]   <= '0;
                cause_valid[l] <= 1'b0;
                cause_to[l]    <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
                to_cnt[l]      <= '0;
`endif
            end
        end else begin
            req_q    <= req_pad;
            req_qq   <= req_q;
            pending  <= pending_nxt;
            rd_drive <= rd_hit;
            rd_data  <= rd_mux;

            if (wr_hit && offset == OFF_ENABLE) enable <= wdata;
            if (wr_hit && offset == OFF_ROUTE)  route  <= wdata;

            for (int l = 0; l < 2; l++) begin
                case (state[l])
                    ST_IDLE: begin
                        if (eligible[l] != 8'h00) begin
                            cause_idx[l]   <= lowest_set(eligible[l]);
                            cause_valid[l] <= 1'b1;
                            raise_q[l]     <= 1'b1;
                            state[l]       <= ST_RAISE;
`ifdef IRQ_TIMEOUT_EN
                            to_cnt[l]      <= '0;
`endif
                        end
                    end
                    ST_RAISE: begin
                        if (BUS_INTERRUPTS_ACK[l]) begin
                            cause_valid[l] <= 1'b0;
                            cause_to[l]    <= 1'b0;
                            raise_q[l]     <= 1'b0;
                            state[l]       <= ST_HOLDOFF;
`ifdef IRQ_TIMEOUT_EN
                        end else if (to_cnt[l] == CNT_LAST) begin
                            // Give up on this request; it stays pending and is re-arbitrated.
                            cause_to[l]    <= 1'b1;
                            raise_q[l]     <= 1'b0;
                            state[l]       <= ST_HOLDOFF;
                        end else begin
                            to_cnt[l]      <= to_cnt[l] + 1'b1;
`endif
                        end
                    end
                    ST_HOLDOFF: state[l] <= ST_IDLE;
                    default:    state[l] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
